// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester handshakes plus the single-port MEMORY connection.
// The arbiter takes the slave view; the requesters/memory side takes the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_LEN = 8,
  parameter int unsigned WORD_LEN = 8
);
  logic                req_a;
  logic                we_a;
  logic [ADDR_LEN-1:0] addr_a;
  logic [WORD_LEN-1:0] wdata_a;
  logic                gnt_a;
  logic                rvalid_a;
  logic [WORD_LEN-1:0] rdata_a;

  logic                req_b;
  logic                we_b;
  logic [ADDR_LEN-1:0] addr_b;
  logic [WORD_LEN-1:0] wdata_b;
  logic                gnt_b;
  logic                rvalid_b;
  logic [WORD_LEN-1:0] rdata_b;

  logic [ADDR_LEN-1:0] mem_addr;
  logic                mem_r_en;
  logic                mem_w_en;
  logic [WORD_LEN-1:0] mem_data_in;
  logic [WORD_LEN-1:0] mem_data_out;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    input  mem_data_out,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output mem_addr, mem_r_en, mem_w_en, mem_data_in
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    output mem_data_out,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  mem_addr, mem_r_en, mem_w_en, mem_data_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising two requesters onto one single-port synchronous memory.
// Every output is registered; a read returns data three cycles after its sampling edge.
module mem_port_arbiter #(
  parameter int unsigned ADDR_LEN = 8,
  parameter int unsigned WORD_LEN = 8
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e state_q, state_d;

  logic                we_q, we_d;
  logic                owner_b_q, owner_b_d;
  logic                last_b_q, last_b_d;
  logic                gnt_a_q, gnt_a_d;
  logic                gnt_b_q, gnt_b_d;
  logic                rvalid_a_q, rvalid_a_d;
  logic                rvalid_b_q, rvalid_b_d;
  logic [WORD_LEN-1:0] rdata_a_q, rdata_a_d;
  logic [WORD_LEN-1:0] rdata_b_q, rdata_b_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_LEN-1:0] mem_data_in_q, mem_data_in_d;
  logic                mem_r_en_q, mem_r_en_d;
  logic                mem_w_en_q, mem_w_en_d;

  logic any_req;
  logic pick_a;

  assign any_req = bus.req_a | bus.req_b;
  // On a tie the requester that did not win last time goes first.
  assign pick_a  = bus.req_a & (~bus.req_b | last_b_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = we_q ? StIdle : StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    we_d          = we_q;
    owner_b_d     = owner_b_q;
    last_b_d      = last_b_q;
    gnt_a_d       = 1'b0;
    gnt_b_d       = 1'b0;
    rvalid_a_d    = 1'b0;
    rvalid_b_d    = 1'b0;
    rdata_a_d     = rdata_a_q;
    rdata_b_d     = rdata_b_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_r_en_d    = 1'b0;
    mem_w_en_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_b_d     = ~pick_a;
          last_b_d      = ~pick_a;
          gnt_a_d       = pick_a;
          gnt_b_d       = ~pick_a;
          we_d          = pick_a ? bus.we_a    : bus.we_b;
          mem_addr_d    = pick_a ? bus.addr_a  : bus.addr_b;
          mem_data_in_d = pick_a ? bus.wdata_a : bus.wdata_b;
          mem_w_en_d    = we_d;
          mem_r_en_d    = ~we_d;
        end
      end
      StIssue: ;
      StResp: begin
        if (owner_b_q) begin
          rdata_b_d  = bus.mem_data_out;
          rvalid_b_d = 1'b1;
        end else begin
          rdata_a_d  = bus.mem_data_out;
          rvalid_a_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Last winner resets to B so that A takes the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q          <= 1'b0;
      owner_b_q     <= 1'b0;
      last_b_q      <= 1'b1;
      gnt_a_q       <= 1'b0;
      gnt_b_q       <= 1'b0;
      rvalid_a_q    <= 1'b0;
      rvalid_b_q    <= 1'b0;
      rdata_a_q     <= '0;
      rdata_b_q     <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_r_en_q    <= 1'b0;
      mem_w_en_q    <= 1'b0;
    end else begin
      we_q          <= we_d;
      owner_b_q     <= owner_b_d;
      last_b_q      <= last_b_d;
      gnt_a_q       <= gnt_a_d;
      gnt_b_q       <= gnt_b_d;
      rvalid_a_q    <= rvalid_a_d;
      rvalid_b_q    <= rvalid_b_d;
      rdata_a_q     <= rdata_a_d;
      rdata_b_q     <= rdata_b_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_r_en_q    <= mem_r_en_d;
      mem_w_en_q    <= mem_w_en_d;
    end
  end

  assign bus.gnt_a       = gnt_a_q;
  assign bus.gnt_b       = gnt_b_q;
  assign bus.rvalid_a    = rvalid_a_q;
  assign bus.rvalid_b    = rvalid_b_q;
  assign bus.rdata_a     = rdata_a_q;
  assign bus.rdata_b     = rdata_b_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_data_in = mem_data_in_q;
  assign bus.mem_r_en    = mem_r_en_q;
  assign bus.mem_w_en    = mem_w_en_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port synchronous MEMORY block (registered read data, write on clock edge).
- Accepts read/write commands from requesters A and B over a req/gnt handshake and serialises them onto the single memory port.
- Returns read data with a one-cycle rvalid pulse to the requester that issued the read.
- Sits between two datapath masters, e.g. a fetch unit and a load/store unit, and one MEMORY instance.

Parameters:
ADDR_LEN, 8, address width; matches MEMORY ADDR_LEN
WORD_LEN, 8, data word width; matches MEMORY WORD_LEN

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
req_a  in  1  requester A command request; held until gnt_a seen
we_a  in  1  A command type: 1 = write, 0 = read
addr_a  in  ADDR_LEN  A address
wdata_a  in  WORD_LEN  A write data
gnt_a  out  1  one-cycle pulse: A command captured
rvalid_a  out  1  one-cycle pulse: rdata_a valid
rdata_a  out  WORD_LEN  A read data
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  same as A, for requester B
mem_addr  out  ADDR_LEN  to MEMORY addr
mem_r_en  out  1  to MEMORY r_en
mem_w_en  out  1  to MEMORY w_en
mem_data_in  out  WORD_LEN  to MEMORY data_in
mem_data_out  in  WORD_LEN  from MEMORY data_out

Behaviour:
- Reset values: all outputs 0; state IDLE; last_winner = B, so A wins the first tie.
- Reset asserted mid-operation clears state and outputs immediately (async). An in-flight read never produces rvalid; an uncompleted write may or may not land (mem_w_en drops at once). Requesters re-issue.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered.
- IDLE:
  - Samples req_a/req_b at the clock edge.
  - If neither is asserted: stay in IDLE.
  - Otherwise choose a winner: sole requester wins; on a tie, the requester that is not last_winner wins.
  - Latch winner's we/addr/wdata into mem_addr/mem_data_in and the command register; set owner and last_winner.
  - Assert that requester's gnt for the next cycle only; go to ISSUE.
- ISSUE, exactly one cycle:
  - mem_r_en = ~we or mem_w_en = we; never both.
  - Write: next state IDLE. Memory updated at the end of ISSUE.
  - Read: next state RESP.
- RESP, one cycle:
  - mem_data_out is valid.
  - At the edge, capture it into the owner's rdata register and set the owner's rvalid for the next cycle; go to IDLE.
- mem_r_en/mem_w_en are 0 in all states except ISSUE. mem_addr/mem_data_in hold their last value.
- rdata_x holds its last captured value until the next read for that requester.
- Latency, counted from the sampling edge E0:
  - gnt and memory access in cycle E0+1.
  - Write visible in memory after edge E1.
  - rvalid/rdata in cycle E0+3.
- Throughput: write one per 2 cycles, read one per 3 cycles.
- rvalid for a finished read may coincide with IDLE sampling the next request.
- Requests present during ISSUE/RESP are ignored and are sampled at the next IDLE edge. A requester sees gnt during ISSUE and must update or drop req by the following edge. A req still held is treated as a new command.
- Fairness: strict round-robin alternation while both requesters are continuously requesting. No requester waits more than one other command.
- Invariants: gnt_a & gnt_b never both 1; rvalid_a & rvalid_b never both 1; mem_r_en & mem_w_en never both 1.

Test Plan:
- Reset: hold rst=1 with req_a=1 -> all outputs 0, no gnt. Release rst -> gnt_a pulses the cycle after the first sampling edge.
- A write then read: A write addr 0x10 data 0xA5 -> gnt_a and mem_w_en=1, mem_addr=0x10 in the same cycle. Then A read 0x10 -> rvalid_a=1, rdata_a=0xA5 three cycles after the sampling edge.
- Tie after reset: A reads 0x01 (preloaded 0x11) and B reads 0x02 (preloaded 0x22) at the same edge -> A granted first, rdata_a=0x11; then gnt_b, rdata_b=0x22. rvalid pulses are never simultaneous.
- Continuous dual writes, A to 0x20.., B to 0x30.. -> grants alternate A,B,A,B, one gnt every 2 cycles; memory contents are correct afterwards.
- Single requester: B issues 4 back-to-back reads, A idle -> all granted to B, one every 3 cycles. rdata_a unchanged and rvalid_a stays 0 throughout.
- Mid-op reset: assert rst during RESP of an A read -> mem_r_en and state clear immediately, rvalid_a never pulses. After release, a new A read completes normally.
